// File: rtl/neuron_mac_if.sv
// Bus between the neuron MAC stage and its neighbours.
// Groups the activation stream (inData/inValid/bias), the weight-memory read
// port (ren/raddr/wout) and the result towards the next layer (outData/outValid).
//   slave  : view taken by the MAC unit
//   master : view taken by the surroundings (activation source, weight memory, sink)
interface neuron_mac_if #(
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
);
    logic [dataWidth-1:0]  inData;
    logic                  inValid;
    logic [dataWidth-1:0]  bias;
    logic                  ren;
    logic [addressWidth:0] raddr;
    logic [dataWidth-1:0]  wout;
    logic [dataWidth-1:0]  outData;
    logic                  outValid;

    modport slave (
        input  inData, inValid, bias, wout,
        output ren, raddr, outData, outValid
    );

    modport master (
        output inData, inValid, bias, wout,
        input  ren, raddr, outData, outValid
    );
endinterface

// File: rtl/neuron_mac_unit.sv
// Per-neuron multiply-accumulate stage.
// Steps the weight-memory address along with the activation stream, multiplies
// each activation by its weight, accumulates with saturation over one vector,
// then adds the bias, rescales, saturates, optionally applies ReLU and emits one
// output word with a single-cycle valid pulse.
// Ports:
//   clk    : clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset
//   mac_if : neuron_mac_if.slave (activation in, weight read port, result out)
module neuron_mac_unit #(
    parameter int numWeight    = 784,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16,
    parameter int fracBits     = 8,
    parameter int reluEn       = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    neuron_mac_if.slave  mac_if
);

    localparam int AccW = 2 * dataWidth;
    localparam logic [addressWidth:0] LastAddr = (addressWidth + 1)'(numWeight - 1);

    localparam logic signed [AccW-1:0] AccMax = {1'b0, {(AccW-1){1'b1}}};
    localparam logic signed [AccW-1:0] AccMin = {1'b1, {(AccW-1){1'b0}}};
    localparam logic signed [AccW-1:0] OutMax = {{(AccW-dataWidth+1){1'b0}}, {(dataWidth-1){1'b1}}};
    localparam logic signed [AccW-1:0] OutMin = {{(AccW-dataWidth+1){1'b1}}, {(dataWidth-1){1'b0}}};

    // Address counter
    logic [addressWidth:0] raddr_q, raddr_d;

    // Stage 1: activation registered alongside the weight read
    logic                  v1_q, first1_q, last1_q;
    logic [dataWidth-1:0]  x_q;

    // Stage 2: product
    logic                  v2_q, first2_q, last2_q;
    logic signed [AccW-1:0] p_q, p_d;

    // Stage 3: accumulator; fin_q marks that acc_q now holds a full vector
    logic signed [AccW-1:0] acc_q, acc_d;
    logic                  fin_q;

    // Stage 4: output register
    logic [dataWidth-1:0]  out_q, out_d;
    logic                  out_valid_q;

    logic signed [AccW-1:0] x_ext, w_ext, acc_sum;
    logic signed [AccW-1:0] bias_ext, bias_sh, fin_sum, fin_sat, r_full;
    logic                   acc_ovf, fin_ovf;

    assign mac_if.ren      = mac_if.inValid;
    assign mac_if.raddr    = raddr_q;
    assign mac_if.outData  = out_q;
    assign mac_if.outValid = out_valid_q;

    always_comb begin
        raddr_d = raddr_q;
        if (mac_if.inValid) begin
            raddr_d = (raddr_q == LastAddr) ? '0 : raddr_q + 1'b1;
        end
    end

    // Full-width product of two dataWidth operands always fits in AccW bits.
    always_comb begin
        x_ext = {{dataWidth{x_q[dataWidth-1]}}, x_q};
        w_ext = {{dataWidth{mac_if.wout[dataWidth-1]}}, mac_if.wout};
        p_d   = x_ext * w_ext;
    end

    // Signed overflow: operands share a sign and the sum's sign differs.
    always_comb begin
        acc_sum = acc_q + p_q;
        acc_ovf = (acc_q[AccW-1] == p_q[AccW-1]) && (acc_sum[AccW-1] != acc_q[AccW-1]);
        acc_d   = acc_q;
        if (v2_q) begin
            if (first2_q) begin
                acc_d = p_q;
            end else if (acc_ovf) begin
                acc_d = p_q[AccW-1] ? AccMin : AccMax;
            end else begin
                acc_d = acc_sum;
            end
        end
    end

    // Finish: the bias is promoted to the product's Q format (2*fracBits)
    // before the add, then the sum is scaled back down to fracBits.
    always_comb begin
        bias_ext = {{dataWidth{mac_if.bias[dataWidth-1]}}, mac_if.bias};
        bias_sh  = bias_ext <<< fracBits;
        fin_sum  = acc_q + bias_sh;
        fin_ovf  = (acc_q[AccW-1] == bias_sh[AccW-1]) && (fin_sum[AccW-1] != acc_q[AccW-1]);
        fin_sat  = fin_ovf ? (acc_q[AccW-1] ? AccMin : AccMax) : fin_sum;
        r_full   = fin_sat >>> fracBits;
        if (r_full > OutMax) begin
            out_d = OutMax[dataWidth-1:0];
        end else if (r_full < OutMin) begin
            out_d = OutMin[dataWidth-1:0];
        end else begin
            out_d = r_full[dataWidth-1:0];
        end
        if ((reluEn != 0) && out_d[dataWidth-1]) begin
            out_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raddr_q     <= '0;
            v1_q        <= 1'b0;
            first1_q    <= 1'b0;
            last1_q     <= 1'b0;
            x_q         <= '0;
            v2_q        <= 1'b0;
            first2_q    <= 1'b0;
            last2_q     <= 1'b0;
            p_q         <= '0;
            acc_q       <= '0;
            fin_q       <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            raddr_q  <= raddr_d;

            v1_q     <= mac_if.inValid;
            first1_q <= mac_if.inValid && (raddr_q == '0);
            last1_q  <= mac_if.inValid && (raddr_q == LastAddr);
            if (mac_if.inValid) begin
                x_q <= mac_if.inData;
            end

            v2_q     <= v1_q;
            first2_q <= first1_q;
            last2_q  <= last1_q;
            if (v1_q) begin
                p_q <= p_d;
            end

            acc_q <= acc_d;
            fin_q <= v2_q && last2_q;

            // acc_q here is the completed total; a following vector's first
            // product is loading acc_q on this same edge without conflict.
            out_valid_q <= fin_q;
            if (fin_q) begin
                out_q <= out_d;
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac_unit.sv
module tb_neuron_mac_unit;

    localparam int NW = 4;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int FB = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    int   wmem[NW];
    int   bias_v;

    typedef struct {
        int exp_relu;
        int exp_lin;
        int due;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // i0: reluEn=0, i1: reluEn=1; both see identical stimulus and weights.
    neuron_mac_if #(.addressWidth(AW), .dataWidth(DW)) i0 ();
    neuron_mac_if #(.addressWidth(AW), .dataWidth(DW)) i1 ();

    neuron_mac_unit #(.numWeight(NW), .addressWidth(AW), .dataWidth(DW),
                      .fracBits(FB), .reluEn(0)) dut_lin (
        .clk(clk), .rst_n(rst_n), .mac_if(i0.slave));

    neuron_mac_unit #(.numWeight(NW), .addressWidth(AW), .dataWidth(DW),
                      .fracBits(FB), .reluEn(1)) dut_relu (
        .clk(clk), .rst_n(rst_n), .mac_if(i1.slave));

    // Weight memories with one-cycle registered read latency.
    always @(posedge clk) if (i0.ren) i0.wout <= 16'(wmem[i0.raddr[1:0]]);
    always @(posedge clk) if (i1.ren) i1.wout <= 16'(wmem[i1.raddr[1:0]]);

    function automatic int model(input int xin[NW], input bit relu);
        longint acc, s, r, pr;
        acc = 0;
        for (int k = 0; k < NW; k++) begin
            pr  = longint'(xin[k]) * longint'(wmem[k]);
            acc = (k == 0) ? pr : acc + pr;
            if (acc > 64'sd2147483647)  acc = 64'sd2147483647;
            if (acc < -64'sd2147483648) acc = -64'sd2147483648;
        end
        s = acc + longint'(bias_v) * 256;
        if (s > 64'sd2147483647)  s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        r = s >>> FB;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        if (relu && r < 0) r = 0;
        return int'(r);
    endfunction

    task automatic push_vec(input int xin[NW]);
        exp_t e;
        e.exp_relu = model(xin, 1'b1);
        e.exp_lin  = model(xin, 1'b0);
        e.due      = cyc + 4;
        sbq.push_back(e);
    endtask

    task automatic drive(input int d);
        @(negedge clk);
        i0.inData = 16'(d);  i1.inData = 16'(d);
        i0.inValid = 1'b1;   i1.inValid = 1'b1;
        i0.bias = 16'(bias_v); i1.bias = 16'(bias_v);
    endtask

    task automatic idle();
        @(negedge clk);
        i0.inValid = 1'b0; i1.inValid = 1'b0;
        i0.inData = '0;    i1.inData = '0;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && sbq.size() != 0; n++) idle();
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: pending=%0d required=0", sbq.size());
            sbq.delete();
        end
        repeat (3) idle();
    endtask

    // Scoreboard consumer: every pulse must match the head entry and its due cycle.
    always @(negedge clk) begin
        if (i0.outValid === 1'b1 || i1.outValid === 1'b1) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL spurious_outvalid: cyc=%0d lin=%b relu=%b required=none", cyc, i0.outValid, i1.outValid);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (cyc !== e.due) begin
                    bad++;
                    $display("FAIL out_latency: cyc=%0d required=%0d", cyc, e.due);
                end
                total++;
                if (i0.outValid !== 1'b1 || i1.outValid !== 1'b1) begin
                    bad++;
                    $display("FAIL out_pair: lin=%b relu=%b required=1 1", i0.outValid, i1.outValid);
                end
                total++;
                if (i0.outData !== 16'(e.exp_lin)) begin
                    bad++;
                    $display("FAIL out_lin: got=%0d required=%0d", $signed(i0.outData), e.exp_lin);
                end
                total++;
                if (i1.outData !== 16'(e.exp_relu)) begin
                    bad++;
                    $display("FAIL out_relu: got=%0d required=%0d", $signed(i1.outData), e.exp_relu);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        i0.inValid = 1'b0; i1.inValid = 1'b0;
        i0.inData = '0; i1.inData = '0;
        i0.bias = '0; i1.bias = '0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (i0.raddr !== '0 || i1.raddr !== '0) begin
            bad++; $display("FAIL reset_raddr: got=%0d/%0d required=0", i0.raddr, i1.raddr);
        end
        total++;
        if (i0.outValid !== 1'b0 || i1.outValid !== 1'b0) begin
            bad++; $display("FAIL reset_outvalid: got=%b/%b required=0", i0.outValid, i1.outValid);
        end
        total++;
        if (i0.outData !== '0 || i1.outData !== '0) begin
            bad++; $display("FAIL reset_outdata: got=%h/%h required=0", i0.outData, i1.outData);
        end
        total++;
        if (i0.ren !== 1'b0) begin
            bad++; $display("FAIL reset_ren: got=%b required=0", i0.ren);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int x[NW] = '{256, 512, 768, 1024};
        wmem = '{256, 256, 256, 256};
        bias_v = 0;
        for (int k = 0; k < NW; k++) begin
            drive(x[k]);
            #1;
            total++;
            if (i0.raddr !== 11'(k) || i0.ren !== 1'b1) begin
                bad++; $display("FAIL basic_raddr%0d: raddr=%0d ren=%b required=%0d 1", k, i0.raddr, i0.ren, k);
            end
        end
        push_vec(x);
        idle();
        #1;
        total++;
        if (i0.raddr !== '0 || i0.ren !== 1'b0) begin
            bad++; $display("FAIL basic_wrap: raddr=%0d ren=%b required=0 0", i0.raddr, i0.ren);
        end
        total++;
        if (sbq[0].exp_lin !== 2560) begin
            bad++; $display("FAIL basic_model: got=%0d required=2560", sbq[0].exp_lin);
        end
        drain();
    endtask

    task automatic test_bias_relu();
        int x[NW] = '{256, 512, 512, 0};
        wmem = '{256, -256, -256, 0};
        bias_v = 128;
        for (int k = 0; k < NW; k++) drive(x[k]);
        push_vec(x);
        drain();
    endtask

    task automatic test_saturation();
        int xp[NW] = '{32767, 32767, 32767, 32767};
        int xn[NW] = '{-32768, -32768, -32768, -32768};
        wmem = '{32767, 32767, 32767, 32767};
        bias_v = 32767;
        for (int k = 0; k < NW; k++) drive(xp[k]);
        push_vec(xp);
        drain();
        for (int k = 0; k < NW; k++) drive(xn[k]);
        push_vec(xn);
        drain();
    endtask

    task automatic test_back_to_back();
        int xa[NW] = '{256, 512, 768, 1024};
        int xb[NW] = '{256, 256, 256, 256};
        wmem = '{256, 256, 256, 256};
        bias_v = 0;
        for (int k = 0; k < NW; k++) drive(xa[k]);
        push_vec(xa);
        for (int k = 0; k < NW; k++) begin
            drive(xb[k]);
            #1;
            total++;
            if (i0.raddr !== 11'(k)) begin
                bad++; $display("FAIL b2b_raddr%0d: got=%0d required=%0d", k, i0.raddr, k);
            end
        end
        push_vec(xb);
        drain();
    endtask

    task automatic test_gapped();
        int x[NW] = '{256, 512, 768, 1024};
        wmem = '{256, 256, 256, 256};
        bias_v = 0;
        drive(x[0]);
        drive(x[1]);
        for (int g = 0; g < 2; g++) begin
            idle();
            #1;
            total++;
            if (i0.ren !== 1'b0 || i0.raddr !== 11'd2) begin
                bad++; $display("FAIL gap1_hold: ren=%b raddr=%0d required=0 2", i0.ren, i0.raddr);
            end
        end
        drive(x[2]);
        for (int g = 0; g < 3; g++) begin
            idle();
            #1;
            total++;
            if (i0.ren !== 1'b0 || i0.raddr !== 11'd3) begin
                bad++; $display("FAIL gap2_hold: ren=%b raddr=%0d required=0 3", i0.ren, i0.raddr);
            end
        end
        drive(x[3]);
        push_vec(x);
        drain();
    endtask

    task automatic test_reset_mid_vector();
        int x[NW] = '{256, 512, 768, 1024};
        wmem = '{256, 256, 256, 256};
        bias_v = 0;
        drive(x[0]);
        drive(x[1]);
        // Reset asserted together with a valid input: the input must be ignored.
        drive(999);
        rst_n = 1'b0;
        #1;
        total++;
        if (i0.raddr !== '0 || i1.raddr !== '0) begin
            bad++; $display("FAIL midrst_raddr: got=%0d/%0d required=0", i0.raddr, i1.raddr);
        end
        total++;
        if (i0.outValid !== 1'b0 || i1.outValid !== 1'b0) begin
            bad++; $display("FAIL midrst_outvalid: got=%b/%b required=0", i0.outValid, i1.outValid);
        end
        idle();
        rst_n = 1'b1;
        #1;
        total++;
        if (i0.raddr !== '0) begin
            bad++; $display("FAIL midrst_ignored_input: raddr=%0d required=0", i0.raddr);
        end
        repeat (6) idle();
        for (int k = 0; k < NW; k++) drive(x[k]);
        push_vec(x);
        drain();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: cyc=%0d required=finish", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_bias_relu();
        test_saturation();
        test_back_to_back();
        test_gapped();
        test_reset_mid_vector();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
